// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory port between IF and MEM, splitting
// multi-byte accesses into byte transfers and reassembling reads little-endian.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              stall_req_if,
    output logic              stall_req_mem,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d, n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ram_a_q, ram_a_d;
    logic [31:0]       wdata_q, wdata_d, buf_q, buf_d;
    logic [31:0]       if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic              sel_mem_q, sel_mem_d, if_done_q, if_done_d, mem_done_q, mem_done_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        buf_d     = buf_q;
        sel_mem_d = sel_mem_q;
        case (state_q)
            IDLE: if (mem_req || if_req) begin
                sel_mem_d = mem_req;
                addr_d    = mem_req ? mem_addr : if_addr;
                wdata_d   = mem_wdata;
                n_d       = (!mem_req || mem_len[1]) ? 3'd4 : mem_len[0] ? 3'd2 : 3'd1;
                state_d   = (mem_req && mem_we) ? WR : RD;
                k_d       = 3'd0;
                buf_d     = 32'd0;
            end
            RD: begin
                // ram_din answers the address presented one cycle earlier
                for (int i = 0; i < 4; i++)
                    if (k_q == 3'(i + 1)) buf_d[8*i +: 8] = ram_din;
                k_d     = k_q + 3'd1;
                state_d = (k_q == n_q) ? DONE : RD;
            end
            WR: begin
                k_d     = k_q + 3'd1;
                state_d = (k_q == n_q - 3'd1) ? DONE : WR;
            end
            default: state_d = IDLE;
        endcase
        if_done_d   = (state_d == DONE) && !sel_mem_d;
        mem_done_d  = (state_d == DONE) && sel_mem_d;
        if_data_d   = if_done_d ? buf_d : if_data_q;
        mem_rdata_d = (mem_done_d && state_q == RD) ? buf_d : mem_rdata_q;
        ram_wr_d    = state_d == WR;
        ram_a_d     = (ram_wr_d || (state_d == RD && k_d < n_d)) ? addr_d + ADDR_W'(k_d) : '0;
        ram_dout_d  = ram_wr_d ? 8'(wdata_d >> {k_d, 3'b000}) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 3'd0;
            n_q         <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            sel_mem_q   <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            ram_wr_q    <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            sel_mem_q   <= sel_mem_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            ram_wr_q    <= ram_wr_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    assign if_done       = if_done_q;
    assign mem_done      = mem_done_q;
    assign if_data       = if_data_q;
    assign mem_rdata     = mem_rdata_q;
    assign ram_wr        = ram_wr_q;
    assign ram_a         = ram_a_q;
    assign ram_dout      = ram_dout_q;
    assign stall_req_if  = if_req & ~if_done_q;
    assign stall_req_mem = mem_req & ~mem_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and random accesses
// checked against a byte-array memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [1:0]  mem_len = '0;
    logic        if_done, mem_done, stall_req_if, stall_req_mem, ram_wr;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic [7:0]  ram_dout, ram_din = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
    );

    logic [7:0] ram [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    int tests = 0, fails = 0;

    function automatic logic [7:0] init_byte(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic int nbytes(logic [1:0] len);
        return len[1] ? 4 : len[0] ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a, logic [1:0] len);
        logic [31:0] r = '0;
        for (int i = 0; i < nbytes(len); i++)
            r[8*i +: 8] = ref_mem.exists(a + 32'(i)) ? ref_mem[a + 32'(i)] : init_byte(a + 32'(i));
        return r;
    endfunction

    // Physical RAM: one-cycle read latency, write on ram_wr
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a] = ram_dout;
        ram_din <= ram_rd(ram_a);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic access(input bit is_if, input bit we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input int exp_lat, input string nm);
        int n, c;
        bit got;
        n = is_if ? 4 : nbytes(len);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
        end
        c = 0;
        got = 1'b0;
        while (!got && c < 20) begin
            tick;
            c++;
            if (c <= n) begin
                chk({nm, "/ram_a"}, ram_a, addr + 32'(c - 1));
                chk({nm, "/ram_wr"}, {31'b0, ram_wr}, {31'b0, we});
                if (we) chk({nm, "/ram_dout"}, {24'b0, ram_dout}, (wdata >> (8 * (c - 1))) & 32'hFF);
            end
            got = is_if ? if_done : mem_done;
            if (!got) chk({nm, "/stall_wait"}, {31'b0, is_if ? stall_req_if : stall_req_mem}, 32'd1);
        end
        chk({nm, "/latency"}, 32'(c), 32'(exp_lat));
        chk({nm, "/stall_done"}, {31'b0, is_if ? stall_req_if : stall_req_mem}, 32'd0);
        if (!we) chk({nm, "/data"}, is_if ? if_data : mem_rdata, exp);
        if_req = 1'b0;
        mem_req = 1'b0;
        if (we) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        tick;
        chk({nm, "/pulse"}, {30'b0, if_done, mem_done}, 32'd0);
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h100,      32'h0,        32'h00000513, 6};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h41,       32'h1234BEEF, 32'h0,        3};
        vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h41,       32'h0,        32'h0000BEEF, 4};
        vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h41,       32'h0,        32'h0201BEEF, 6};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h42,       32'h0,        32'h000000BE, 3};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 32'h20,       32'h0,        32'h000000AB, 3};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0,        32'h44332211, 6};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 32'h203,      32'hCAFEF00D, 32'h0,        5};
        vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h203,      32'h0,        32'hCAFEF00D, 6};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'h205,      32'hFFFFFF77, 32'h0,        2};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h203,      32'h0,        32'hCA77F00D, 6};
        vecs[11] = '{1'b0, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0,        32'h00003322, 4};
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        poke(32'h20, 8'hAB); poke(32'h43, 8'h01); poke(32'h44, 8'h02);
        poke(32'hFFFFFFFE, 8'h11); poke(32'hFFFFFFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);

        // Reset state
        repeat (3) tick;
        chk("rst/ram_wr", {31'b0, ram_wr}, 32'd0);
        chk("rst/ram_a", ram_a, 32'd0);
        chk("rst/ram_dout", {24'b0, ram_dout}, 32'd0);
        chk("rst/done", {30'b0, if_done, mem_done}, 32'd0);
        chk("rst/if_data", if_data, 32'd0);
        chk("rst/mem_rdata", mem_rdata, 32'd0);
        chk("rst/stall", {30'b0, stall_req_if, stall_req_mem}, 32'd0);
        rst = 1'b0;
        tick;

        foreach (vecs[i])
            access(vecs[i].is_if, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
        chk("if_data_hold", if_data, 32'h44332211);

        // Simultaneous requests: MEM first, IF granted in the IDLE after MEM's DONE
        begin
            logic [31:0] exp_if;
            poke(32'h20, 8'hAB);
            exp_if = ref_read(32'h0, 2'd2);
            mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h20;
            if_req = 1'b1; if_addr = 32'h0;
            for (int c = 1; c <= 12; c++) begin
                tick;
                chk($sformatf("both/done_c%0d", c), {30'b0, if_done, mem_done}, {30'b0, c == 10, c == 3});
                if (c < 10) chk($sformatf("both/stall_if_c%0d", c), {31'b0, stall_req_if}, 32'd1);
                if (c == 3) begin
                    chk("both/mem_rdata", mem_rdata, 32'h000000AB);
                    chk("both/stall_mem", {31'b0, stall_req_mem}, 32'd0);
                    mem_req = 1'b0;
                end
                if (c == 10) begin
                    chk("both/if_data", if_data, exp_if);
                    chk("both/stall_if_done", {31'b0, stall_req_if}, 32'd0);
                    if_req = 1'b0;
                end
            end
        end

        // Reset during the second write cycle of a word store
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h80; mem_wdata = 32'h11223344;
        tick;
        tick;
        chk("rstwr/ram_wr_c2", {31'b0, ram_wr}, 32'd1);
        rst = 1'b1;
        mem_req = 1'b0;
        tick;
        chk("rstwr/ram_wr", {31'b0, ram_wr}, 32'd0);
        chk("rstwr/ram_a", ram_a, 32'd0);
        chk("rstwr/ram_dout", {24'b0, ram_dout}, 32'd0);
        chk("rstwr/mem_rdata", mem_rdata, 32'd0);
        chk("rstwr/if_data", if_data, 32'd0);
        rst = 1'b0;
        ref_mem[32'h80] = 8'h44;
        ref_mem[32'h81] = 8'h33;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("rstwr/no_done", {30'b0, if_done, mem_done}, 32'd0);
            chk("rstwr/idle_wr", {31'b0, ram_wr}, 32'd0);
        end
        access(1'b0, 1'b0, 2'd2, 32'h80, 32'h0, ref_read(32'h80, 2'd2), 6, "rstwr/readback");

        // Request held after done: one access per done, stall low only in done cycles
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 13; c++) begin
            tick;
            chk($sformatf("hold/done_c%0d", c), {31'b0, if_done}, {31'b0, c == 6 || c == 13});
            chk($sformatf("hold/stall_c%0d", c), {31'b0, stall_req_if}, {31'b0, !(c == 6 || c == 13)});
            if (c == 6 || c == 13) chk("hold/if_data", if_data, 32'h00000513);
            if (c == 7) chk("hold/idle_ram_a", ram_a, 32'd0);
        end
        if_req = 1'b0;
        tick;
        chk("hold/after", {31'b0, if_done}, 32'd0);

        // Random accesses against the byte-array model
        for (int r = 0; r < 150; r++) begin
            bit          is_if, we;
            logic [1:0]  len;
            logic [31:0] addr, wdata;
            int          n;
            is_if = $urandom_range(0, 2) == 0;
            we    = !is_if && ($urandom_range(0, 1) == 1);
            len   = is_if ? 2'd2 : 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                : 32'h300 + 32'($urandom_range(0, 31));
            wdata = $urandom;
            n     = nbytes(len);
            access(is_if, we, len, addr, wdata, we ? 32'h0 : ref_read(addr, len),
                   we ? n + 1 : n + 2, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
